vid_timing_monitor: RTL and testbench
=====================================

VID_TIMING_MONITOR -- requirements
Module: vid_timing_monitor

Interface
REQ-001 SHALL have parameter HS_ACTIVE_HIGH, default 1; 1 = hsync asserted high, 0 = asserted low.
REQ-002 SHALL have parameter VS_ACTIVE_HIGH, default 1; same meaning for vsync.
REQ-003 SHALL have parameter STABLE_FRAMES, default 2, range 1-15; identical frames required before lock.
REQ-004 SHALL have parameter TIMEOUT_LOG2, default 22; no-vsync timeout is 2^TIMEOUT_LOG2 clocks.
REQ-005 clk  in  1  pixel clock; the one clock, all logic on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 vid_de  in  1  data enable, active high.
REQ-008 vid_hs  in  1  horizontal sync, polarity per HS_ACTIVE_HIGH.
REQ-009 vid_vs  in  1  vertical sync, polarity per VS_ACTIVE_HIGH.
REQ-010 meas_h_total  out  12  clocks per line minus 1.
REQ-011 meas_h_active  out  12  de-high clocks per active line.
REQ-012 meas_v_total  out  12  lines per frame minus 1.
REQ-013 meas_v_active  out  12  lines per frame containing de.
REQ-014 meas_valid  out  1  meas_* are locked and current.
REQ-015 fmt_change  out  1  one-clock pulse when lock is lost by mismatch.
REQ-016 no_signal  out  1  vsync timeout active.

Function
REQ-017 SHALL register vid_de/hs/vs once (s1) then again (s2); hs_edge = s1 asserted and s2 deasserted; vs_edge likewise; de uses s1.
REQ-018 SHALL run h_cnt, 12 bits: 0 on hs_edge, else +1, saturating at 4095; saturation sets frame-bad flag.
REQ-019 On hs_edge, line length = h_cnt (gives total-1); line de count = de_cnt; de_cnt restarts at s1.de (0/1); a nonzero de count is latched as the frame candidate h_active.
REQ-020 SHALL count hs_edges per frame: on vs_edge, v_cnt <= 1 if hs_edge in same cycle else 0; coincident hs_edge belongs to new frame; candidate v_total = v_cnt - 1.
REQ-021 Line has-de flag set by s1.de, cleared on hs_edge after incrementing vde_cnt; on vs_edge, candidate v_active = vde_cnt + pending flag; both cleared.
REQ-022 Candidate h_total = last line length in frame; any line length differing within one frame sets frame-bad.
REQ-023 States: SEARCH (reset; waits for first vs_edge, no candidate), MEASURE (frames captured, not locked), LOCKED.
REQ-024 SEARCH -> MEASURE on first vs_edge; no candidate produced from that edge.
REQ-025 In MEASURE, each vs_edge closes a frame: bad frame -> match_cnt 0; candidate equal to previous -> match_cnt+1; else match_cnt 1, store candidate.
REQ-026 MEASURE -> LOCKED when match_cnt reaches STABLE_FRAMES: meas_* <= candidate, meas_valid <= 1, on the clock edge after the vs_edge cycle (2 clocks after vid_vs sampled asserted).
REQ-027 In LOCKED, a frame differing or bad -> meas_valid 0, fmt_change 1 for exactly one clock, match_cnt 1 (0 if bad), state MEASURE.
REQ-028 meas_* SHALL hold last published values while meas_valid = 0.
REQ-029 Timeout counter clears on vs_edge; at 2^TIMEOUT_LOG2-1 -> no_signal 1, meas_valid 0, state SEARCH, no fmt_change; no_signal clears on next vs_edge.
REQ-030 Simultaneous vs_edge and timeout terminal count: vs_edge wins.

Reset
REQ-031 reset_n low SHALL asynchronously force state SEARCH, all counters/flags/candidates 0, meas_* 0, meas_valid 0, fmt_change 0, no_signal 0.
REQ-032 Reset mid-frame SHALL discard partial measurement; the first frame after release is not used.

Verification
REQ-033 640x480 (800x525, de 640x480, vs aligned with hs), STABLE_FRAMES=2 -> meas_valid rises 2 clocks after 3rd vs assertion; meas = 799/640/524/480.
REQ-034 Locked 1920x1080 (2200x1125) switched to 1280x1024 (1688x1066) -> fmt_change one pulse at first mismatched vs, old values held, relock at 1687/1280/1065/1024.
REQ-035 vs asserted mid-line (not with hs), 720x480 (858x525) -> v_total 524, v_active 480, identical to aligned case.
REQ-036 TIMEOUT_LOG2=10, vs stopped while locked -> no_signal 1 after 1023 clocks, meas_valid 0, fmt_change stays 0; vs restart -> no_signal 0, relock after STABLE_FRAMES frames.
REQ-037 hs stuck inactive for 5000 clocks within a frame -> frame-bad, no lock that frame; reset_n low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/vid_timing_monitor.sv
// Video timing monitor: measures h/v totals and active sizes from DE/HSYNC/VSYNC,
// locks after STABLE_FRAMES identical frames, flags format changes and loss of vsync.
module vid_timing_monitor #(
  parameter bit          HS_ACTIVE_HIGH = 1'b1,
  parameter bit          VS_ACTIVE_HIGH = 1'b1,
  parameter int unsigned STABLE_FRAMES  = 2,
  parameter int unsigned TIMEOUT_LOG2   = 22
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vid_de,
  input  logic        vid_hs,
  input  logic        vid_vs,
  output logic [11:0] meas_h_total,
  output logic [11:0] meas_h_active,
  output logic [11:0] meas_v_total,
  output logic [11:0] meas_v_active,
  output logic        meas_valid,
  output logic        fmt_change,
  output logic        no_signal
);

  localparam int unsigned CW = 12;
  localparam int unsigned MW = 4;
  localparam int unsigned TW = TIMEOUT_LOG2;

  typedef struct packed {
    logic [CW-1:0] ht;
    logic [CW-1:0] ha;
    logic [CW-1:0] vt;
    logic [CW-1:0] va;
  } timing_t;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  logic          hs_act, vs_act;
  logic          s1_de_q, s1_hs_q, s1_vs_q, s2_hs_q, s2_vs_q;
  logic          hs_edge, vs_edge, to_term;
  logic [CW-1:0] h_cnt_q, h_cnt_d, de_cnt_q, de_cnt_d, len_last_q, len_last_d;
  logic [CW-1:0] cand_ht_q, cand_ht_d, cand_ha_q, cand_ha_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d, vde_cnt_q, vde_cnt_d;
  logic          have_len_q, have_len_d, bad_q, bad_d, line_de_q, line_de_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  state_t        state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  timing_t       prev_q, prev_d, meas_q, meas_d, cand_c;
  logic          meas_valid_q, meas_valid_d, fmt_change_q, fmt_change_d;
  logic          no_signal_q, no_signal_d;

  assign hs_act  = HS_ACTIVE_HIGH ? vid_hs : ~vid_hs;
  assign vs_act  = VS_ACTIVE_HIGH ? vid_vs : ~vid_vs;
  assign hs_edge = s1_hs_q & ~s2_hs_q;
  assign vs_edge = s1_vs_q & ~s2_vs_q;
  assign to_term = (to_cnt_q == '1) & ~vs_edge;
  assign cand_c  = {cand_ht_q, cand_ha_q, v_cnt_q - CW'(1), vde_cnt_q + CW'(line_de_q)};

  // Per-line and per-frame counters; a vs_edge starts a fresh frame, and a
  // coincident hs_edge only contributes its line start to the new frame.
  always_comb begin
    h_cnt_d    = h_cnt_q;
    de_cnt_d   = de_cnt_q;
    len_last_d = len_last_q;
    have_len_d = have_len_q;
    bad_d      = bad_q;
    cand_ht_d  = cand_ht_q;
    cand_ha_d  = cand_ha_q;
    v_cnt_d    = v_cnt_q;
    vde_cnt_d  = vde_cnt_q;
    line_de_d  = line_de_q;
    to_cnt_d   = vs_edge ? '0 : to_cnt_q + TW'(1);
    if (hs_edge) begin
      h_cnt_d    = '0;
      de_cnt_d   = CW'(s1_de_q);
      cand_ht_d  = h_cnt_q;
      len_last_d = h_cnt_q;
      have_len_d = 1'b1;
      if (de_cnt_q != '0) cand_ha_d = de_cnt_q;
      if (have_len_q && (h_cnt_q != len_last_q)) bad_d = 1'b1;
      if (v_cnt_q != '1) v_cnt_d = v_cnt_q + CW'(1);
      vde_cnt_d  = vde_cnt_q + CW'(line_de_q);
      line_de_d  = s1_de_q;
    end else begin
      if (h_cnt_q == '1) bad_d = 1'b1;
      else               h_cnt_d = h_cnt_q + CW'(1);
      de_cnt_d   = de_cnt_q + CW'(s1_de_q);
      line_de_d  = line_de_q | s1_de_q;
    end
    if (vs_edge) begin
      v_cnt_d    = CW'(hs_edge);
      vde_cnt_d  = '0;
      line_de_d  = s1_de_q;
      bad_d      = 1'b0;
      have_len_d = 1'b0;
    end
  end

  // Lock FSM: frames close on vs_edge; the timeout only acts without one.
  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    prev_d       = prev_q;
    meas_d       = meas_q;
    meas_valid_d = meas_valid_q;
    fmt_change_d = 1'b0;
    no_signal_d  = no_signal_q;
    if (vs_edge) begin
      no_signal_d = 1'b0;
      case (state_q)
        SEARCH: begin
          state_d = MEASURE;
          match_d = '0;
        end
        MEASURE: begin
          if (bad_q) begin
            match_d = '0;
          end else begin
            if (cand_c == prev_q) begin
              match_d = match_q + MW'(1);
            end else begin
              match_d = MW'(1);
              prev_d  = cand_c;
            end
            if (match_d == MW'(STABLE_FRAMES)) begin
              state_d      = LOCKED;
              meas_d       = cand_c;
              meas_valid_d = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (bad_q || (cand_c != meas_q)) begin
            state_d      = MEASURE;
            meas_valid_d = 1'b0;
            fmt_change_d = 1'b1;
            match_d      = bad_q ? MW'(0) : MW'(1);
            if (!bad_q) prev_d = cand_c;
          end
        end
        default: state_d = SEARCH;
      endcase
    end else if (to_term) begin
      state_d      = SEARCH;
      match_d      = '0;
      meas_valid_d = 1'b0;
      no_signal_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_de_q <= 1'b0; s1_hs_q <= 1'b0; s1_vs_q <= 1'b0;
      s2_hs_q <= 1'b0; s2_vs_q <= 1'b0;
      h_cnt_q <= '0; de_cnt_q <= '0; len_last_q <= '0; have_len_q <= 1'b0;
      bad_q <= 1'b0; cand_ht_q <= '0; cand_ha_q <= '0;
      v_cnt_q <= '0; vde_cnt_q <= '0; line_de_q <= 1'b0; to_cnt_q <= '0;
      state_q <= SEARCH; match_q <= '0; prev_q <= '0; meas_q <= '0;
      meas_valid_q <= 1'b0; fmt_change_q <= 1'b0; no_signal_q <= 1'b0;
    end else begin
      s1_de_q <= vid_de; s1_hs_q <= hs_act; s1_vs_q <= vs_act;
      s2_hs_q <= s1_hs_q; s2_vs_q <= s1_vs_q;
      h_cnt_q <= h_cnt_d; de_cnt_q <= de_cnt_d; len_last_q <= len_last_d;
      have_len_q <= have_len_d; bad_q <= bad_d;
      cand_ht_q <= cand_ht_d; cand_ha_q <= cand_ha_d;
      v_cnt_q <= v_cnt_d; vde_cnt_q <= vde_cnt_d; line_de_q <= line_de_d;
      to_cnt_q <= to_cnt_d;
      state_q <= state_d; match_q <= match_d; prev_q <= prev_d; meas_q <= meas_d;
      meas_valid_q <= meas_valid_d; fmt_change_q <= fmt_change_d;
      no_signal_q <= no_signal_d;
    end
  end

  assign meas_h_total  = meas_q.ht;
  assign meas_h_active = meas_q.ha;
  assign meas_v_total  = meas_q.vt;
  assign meas_v_active = meas_q.va;
  assign meas_valid    = meas_valid_q;
  assign fmt_change    = fmt_change_q;
  assign no_signal     = no_signal_q;

endmodule

// File: tb/tb_vid_timing_monitor.sv
// Directed bench for vid_timing_monitor using scaled-down video formats
// (active-low hsync, active-high vsync) so every scenario fits in a short run.
module tb_vid_timing_monitor;

  typedef struct {
    int ht;
    int ha;
    int vt;
    int va;
    int off;
  } fmt_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vid_de = 1'b0;
  logic        vid_hs = 1'b1;
  logic        vid_vs = 1'b0;
  logic [11:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;
  logic        meas_valid, fmt_change, no_signal;

  int errs   = 0;
  int checks = 0;
  int fc_cnt = 0;

  vid_timing_monitor #(
    .HS_ACTIVE_HIGH(1'b0),
    .VS_ACTIVE_HIGH(1'b1),
    .STABLE_FRAMES (2),
    .TIMEOUT_LOG2  (13)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vid_de       (vid_de),
    .vid_hs       (vid_hs),
    .vid_vs       (vid_vs),
    .meas_h_total (meas_h_total),
    .meas_h_active(meas_h_active),
    .meas_v_total (meas_v_total),
    .meas_v_active(meas_v_active),
    .meas_valid   (meas_valid),
    .fmt_change   (fmt_change),
    .no_signal    (no_signal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fmt_change) fc_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock slot: outputs read after return reflect this edge; pixel p drives inputs.
  // Line layout: hs 4 clocks at col 0, de from col 6, de lines from line 3, vs 2 lines from off.
  task automatic pix(input fmt_t f, input int p, input bit novs);
    int l, c;
    @(posedge clk);
    #1;
    l = p / f.ht;
    c = p % f.ht;
    vid_hs = !(c < 4);
    vid_de = (l >= 3) && (l < 3 + f.va) && (c >= 6) && (c < 6 + f.ha);
    vid_vs = !novs && (p >= f.off) && (p < f.off + 2 * f.ht);
  endtask

  task automatic span(input fmt_t f, input int p0, input int n, input bit novs);
    int len;
    len = f.ht * f.vt;
    for (int i = 0; i < n; i++) pix(f, (p0 + i) % len, novs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      vid_hs = 1'b1;
      vid_de = 1'b0;
      vid_vs = 1'b0;
    end
  endtask

  task automatic chk_meas(input string tag, input fmt_t f);
    chk({tag, ".ht"}, int'(meas_h_total),  f.ht - 1);
    chk({tag, ".ha"}, int'(meas_h_active), f.ha);
    chk({tag, ".vt"}, int'(meas_v_total),  f.vt - 1);
    chk({tag, ".va"}, int'(meas_v_active), f.va);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ht"}, int'(meas_h_total), 0);
    chk({tag, ".ha"}, int'(meas_h_active), 0);
    chk({tag, ".vt"}, int'(meas_v_total), 0);
    chk({tag, ".va"}, int'(meas_v_active), 0);
    chk({tag, ".mv"}, int'(meas_valid), 0);
    chk({tag, ".fc"}, int'(fmt_change), 0);
    chk({tag, ".ns"}, int'(no_signal), 0);
  endtask

  // Start a frame and stop at the slot two clocks after vs is sampled.
  task automatic frame_head(input fmt_t f);
    span(f, 0, f.off + 3, 1'b0);
  endtask

  task automatic frame_tail(input fmt_t f);
    span(f, f.off + 3, f.ht * f.vt - f.off - 3, 1'b0);
  endtask

  initial begin
    fmt_t a, b, c;
    int   lb, n1, p;
    a  = '{40, 32, 12, 8, 0};
    b  = '{56, 48, 15, 10, 0};
    c  = '{44, 30, 13, 9, 13};
    lb = b.ht * b.vt;

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    // Format A: lock on the third vs, exactly two clocks after it is sampled
    span(a, 0, 2 * a.ht * a.vt, 1'b0);
    span(a, 0, 2, 1'b0);
    chk("a_pre_lock", int'(meas_valid), 0);
    span(a, 2, 1, 1'b0);
    chk("a_lock", int'(meas_valid), 1);
    chk_meas("a", a);
    span(a, 3, a.ht * a.vt - 3, 1'b0);
    span(a, 0, a.ht * a.vt, 1'b0);

    // Switch to format B: one fmt_change pulse, old values held, then relock
    span(b, 0, lb, 1'b0);
    frame_head(b);
    chk("b_fc", int'(fmt_change), 1);
    chk("b_mv", int'(meas_valid), 0);
    chk_meas("b_hold", a);
    span(b, 3, 1, 1'b0);
    chk("b_fc_one", int'(fmt_change), 0);
    span(b, 4, lb - 4, 1'b0);
    frame_head(b);
    chk("b_lock", int'(meas_valid), 1);
    chk_meas("b", b);
    frame_tail(b);
    chk("b_fc_cnt", fc_cnt, 1);

    // Hsync stuck inactive for 5000 clocks makes the frame bad
    span(b, 0, 4 * b.ht, 1'b0);
    idle(5000);
    frame_head(b);
    chk("stuck_fc", int'(fmt_change), 1);
    chk("stuck_mv", int'(meas_valid), 0);
    chk_meas("stuck_hold", b);
    frame_tail(b);
    frame_head(b);
    chk("stuck_no_lock", int'(meas_valid), 0);
    frame_tail(b);
    frame_head(b);
    chk("stuck_relock", int'(meas_valid), 1);
    chk_meas("stuck_re", b);
    frame_tail(b);
    chk("stuck_fc_cnt", fc_cnt, 2);

    // Vsync stops while locked: no_signal after 2^13-1 clocks, no fmt_change
    n1 = 8194 - lb;
    span(b, 0, n1, 1'b1);
    chk("to_before_ns", int'(no_signal), 0);
    chk("to_before_mv", int'(meas_valid), 1);
    span(b, n1 % lb, 1, 1'b1);
    chk("to_ns", int'(no_signal), 1);
    chk("to_mv", int'(meas_valid), 0);
    chk("to_fc", int'(fmt_change), 0);
    p = (n1 + 1) % lb;
    span(b, p, lb - p, 1'b1);
    span(b, 0, lb, 1'b1);
    chk("to_fc_cnt", fc_cnt, 2);
    chk("to_ns_hold", int'(no_signal), 1);
    chk_meas("to_hold", b);

    // Vsync restarts: no_signal clears, relock after two captured frames
    frame_head(b);
    chk("re_ns", int'(no_signal), 0);
    chk("re_mv0", int'(meas_valid), 0);
    frame_tail(b);
    frame_head(b);
    chk("re_mv1", int'(meas_valid), 0);
    frame_tail(b);
    frame_head(b);
    chk("re_lock", int'(meas_valid), 1);
    chk_meas("re", b);
    span(b, 3, 300, 1'b0);

    // Asynchronous reset mid-frame clears outputs immediately
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    span(c, 200, 2, 1'b0);
    reset_n = 1'b1;
    span(c, 202, c.ht * c.vt - 202, 1'b0);

    // Format C with vs mid-line: same totals as an aligned vs would give
    frame_head(c);
    chk("c_mv0", int'(meas_valid), 0);
    frame_tail(c);
    frame_head(c);
    chk("c_mv1", int'(meas_valid), 0);
    frame_tail(c);
    span(c, 0, c.off + 2, 1'b0);
    chk("c_pre_lock", int'(meas_valid), 0);
    span(c, c.off + 2, 1, 1'b0);
    chk("c_lock", int'(meas_valid), 1);
    chk_meas("c", c);
    frame_tail(c);
    chk("end_fc_cnt", fc_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
